// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP result transmitter.
// The state enum is shared so the top and any observers agree on encoding.
package msdap_pkg;

  localparam int ACC_W = 40;
  localparam int CNT_W = 6;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/tx_piso.sv
// Parallel-in / serial-out shift register, MSB first, zero fill on shift.
// Load takes priority over shift so a back-to-back reload wins on the last tick.
module tx_piso #(
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [ACC_W-1:0] din,
  output logic             dout
);

  logic [ACC_W-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_sr <= '0;
    end else if (load) begin
      r_sr <= din;
    end else if (shift) begin
      r_sr <= {r_sr[ACC_W-2:0], 1'b0};
    end
  end

  assign dout = r_sr[ACC_W-1];

endmodule

// File: rtl/msdap_output_tx.sv
// Stereo result transmitter: one-deep holding buffer feeding two PISO shifters
// paced by bit_tick, with frame-active and frame-done strobes.
module msdap_output_tx
  import msdap_pkg::*;
#(
  parameter int ACC_W = msdap_pkg::ACC_W,
  parameter int CNT_W = msdap_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             bit_tick,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [ACC_W-1:0] res_left,
  input  logic [ACC_W-1:0] res_right,
  output logic             out_ready,
  output logic             out_left,
  output logic             out_right,
  output logic             frame_done
);

  tx_state_e        r_state;
  logic             r_hold_full;
  logic [ACC_W-1:0] r_hold_l;
  logic [ACC_W-1:0] r_hold_r;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_frame_done;

  logic w_accept;
  logic w_tick_shift;
  logic w_last;
  logic w_load;

  assign w_accept     = res_valid && !r_hold_full;
  assign w_tick_shift = (r_state == TX_SHIFT) && bit_tick;
  assign w_last       = w_tick_shift && (r_bit_cnt == CNT_W'(ACC_W - 1));
  // The held pair moves into the shifters when idle, or on the final tick of a frame.
  assign w_load       = r_hold_full && ((r_state == TX_IDLE) || w_last);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state      <= TX_IDLE;
      r_hold_full  <= 1'b0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;

      if (w_accept) begin
        r_hold_l    <= res_left;
        r_hold_r    <= res_right;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (r_state == TX_IDLE) begin
        if (r_hold_full) begin
          r_state   <= TX_SHIFT;
          r_bit_cnt <= '0;
        end
      end else if (bit_tick) begin
        if (w_last) begin
          r_bit_cnt <= '0;
          if (!r_hold_full) begin
            r_state <= TX_IDLE;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign res_ready  = !r_hold_full;
  assign out_ready  = (r_state == TX_SHIFT);
  assign frame_done = r_frame_done;

  tx_piso #(.ACC_W(ACC_W)) u_piso_left (
    .clk   (clk),
    .clear (clear),
    .load  (w_load),
    .shift (w_tick_shift),
    .din   (r_hold_l),
    .dout  (out_left)
  );

  tx_piso #(.ACC_W(ACC_W)) u_piso_right (
    .clk   (clk),
    .clear (clear),
    .load  (w_load),
    .shift (w_tick_shift),
    .din   (r_hold_r),
    .dout  (out_right)
  );

endmodule

// File: doc/msdap_output_tx.md
# msdap_output_tx

Stereo result transmitter for the MSDAP datapath. Accepts one 40-bit left/right accumulator pair per frame from the two ALU channels through a valid/ready handshake. Holds the pair in a one-deep holding buffer and shifts both words out serially, MSB first, on paced bit ticks. Raises a frame-active strobe while shifting, and pulses a done flag when each frame completes.

## Interface
Parameters:
- `ACC_W`, default 40, accumulator/result width in bits.
- `CNT_W`, default 6, bit-counter width; must satisfy 2**CNT_W >= ACC_W.

Ports:
- `clk` input 1: system clock (SCLK); only clock.
- `clear` input 1: reset, synchronous, active-high.
- `bit_tick` input 1: one-cycle pacing strobe; one bit advances per high cycle.
- `res_valid` input 1: result pair on `res_left`/`res_right` is valid.
- `res_ready` output 1: holding buffer empty; transfer occurs on a `res_valid && res_ready` clock edge.
- `res_left` input ACC_W: left-channel accumulator, two's complement.
- `res_right` input ACC_W: right-channel accumulator, two's complement.
- `out_ready` output 1: high while a frame is being shifted.
- `out_left` output 1: left serial bit, equal to the current left shift-register MSB.
- `out_right` output 1: right serial bit, equal to the current right shift-register MSB.
- `frame_done` output 1: one-cycle pulse after the last bit of a frame.

## Operation
- Reset values: `res_ready`=1, `out_ready`=0, `out_left`=0, `out_right`=0, `frame_done`=0. Holding buffer and both shift registers are zeroed, `bit_cnt`=0, state TX_IDLE.
- Holding buffer: `hold_full` flag plus two ACC_W registers. `res_ready` = !`hold_full`, with no combinational path from `res_valid`.
  - Accept edge: capture both words and set `hold_full`.
  - `hold_full` clears on the edge where the buffer transfers into the shifters.
- FSM states are TX_IDLE and TX_SHIFT.
- TX_IDLE:
  - If `hold_full`, on the next edge load both shifters from hold, clear `hold_full`, set `bit_cnt`=0, and go to TX_SHIFT.
  - `bit_tick` is ignored in TX_IDLE.
- TX_SHIFT:
  - On `bit_tick`, shift both registers left by one (zero fill) and increment `bit_cnt`.
  - On the tick where `bit_cnt`==ACC_W-1 (the last bit), the frame ends and `frame_done` is registered high for exactly one cycle.
  - If `hold_full` on that edge, reload the shifters from hold, clear `hold_full`, reset `bit_cnt` to 0, and stay in TX_SHIFT. `out_ready` stays high with no gap.
  - Otherwise go to TX_IDLE and drop `out_ready`.
- `out_ready` is high exactly when state is TX_SHIFT.
- `out_left`/`out_right` are driven directly from shift-register bit ACC_W-1. They read 0 in TX_IDLE because the shift-outs zero-fill.
- No arithmetic is performed: words are transmitted bit-exact, sign bit first.
- Boundary conditions:
  - An accept and a transfer cannot coincide, because `res_ready`=0 whenever `hold_full`=1.
  - A new pair can be accepted one cycle after the transfer, while the previous frame is still shifting.
  - `res_valid` held high with `res_ready`=0 is a stall: inputs must stay stable and no capture occurs.
  - `clear` asserted mid-frame abandons the partial frame and any held pair at the next edge; no `frame_done` is issued.
  - `bit_tick` held high continuously gives ACC_W cycles per frame.

## Timing
- Accept at edge N, shifter idle: `res_ready` low after N; transfer at N+1; `out_ready`=1 and bit 39 visible after N+1; `res_ready` high again after N+1.
- Each subsequent `bit_tick` edge exposes the next bit. Bit k (MSB = bit ACC_W-1) is valid from the edge of tick ACC_W-1-k until the next tick edge.
- `frame_done` is high in the cycle after the last-bit tick edge, coincident with `out_ready` falling (or staying high on back-to-back frames).
- Accept-to-first-bit latency is 1 cycle when idle. When busy, the held pair starts on the edge of the current frame's last tick.

## Structure
- Shared package `msdap_pkg`:
  - constant `ACC_W`=40;
  - `typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e`.
- Sub-module `tx_piso`: ACC_W-bit parallel-in/serial-out register with `load`, `shift` and `dout` (MSB). Instantiated twice, once per channel.
- The top holds the FSM, holding buffer, bit counter and handshake.

## Test plan
- Reset, then idle 5 cycles → `res_ready`=1, `out_ready`=0, `out_left`=`out_right`=0, `frame_done`=0.
- Accept L=40'h80_0000_0001, R=40'h7F_FFFF_FFFE with `bit_tick` always high → 40 serial bits per channel matching MSB-first (L: 1, 38 zeros, 1); one `frame_done` after 40 ticks.
- `bit_tick` every 3rd cycle, L=40'hA5A5A5A5A5 → a bit changes only on tick edges; frame lasts 120 cycles.
- Accept a second pair (L=40'h1, R=40'h2) during frame 1 → `res_ready` low until frame 1 ends; frame 2 starts with no `out_ready` gap; `frame_done` pulses twice.
- Hold `res_valid` high while `res_ready`=0 with changing data → only the value present at the ready edge is transmitted.
- Assert `clear` at bit 20 of a frame with a pair held → outputs return to reset values next edge; no `frame_done`; nothing further transmitted.
